// File: rtl/sra_pkg.sv
// Shared definitions for the round-robin shared-register arbiter:
// state encoding, elaboration-time log2 and data-slice offset helper.
package sra_pkg;

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_WRITE = 1'b1;

    typedef enum logic {
        ST_IDLE  = S_IDLE,
        ST_WRITE = S_WRITE
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Low bit of requester idx's slice in a packed N*width data bus.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_en_register.sv
// WIDTH-bit bank of enable flip-flops; clears asynchronously, loads d when en is high.
module en_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage: hold unless enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {WIDTH{1'b0}};
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one enabled register among N requesters;
// each grant performs a single one-cycle write of data captured at the decision edge.
module shared_reg_arbiter
    import sra_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    localparam int IW   = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic               Clock,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] wdata,
    output logic [N-1:0]       gnt,
    output logic               busy,
    output logic [IW-1:0]      owner,
    output logic [WIDTH-1:0]   q
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] ONE_IDX  = IW'(1);

    state_e            state_r, state_s;
    logic [IW-1:0]     ptr_r, ptr_s;
    logic [IW-1:0]     sel_r, sel_s;
    logic [IW-1:0]     owner_r, owner_s;
    logic [IW-1:0]     win_s;
    logic [WIDTH-1:0]  hold_r, hold_s;
    logic [N-1:0]      gnt_r, gnt_s;
    logic              busy_r, busy_s;
    logic [2*N-1:0]    dbl_s;
    logic [N-1:0]      rot_s;
    logic              any_s;
    logic              wr_en_s;
    int                off_s;
    int                sum_s;

    // Round-robin search: rotate req so ptr sits at bit 0, take the lowest set bit
    always_comb begin
        dbl_s = {req, req} >> ptr_r;
        rot_s = dbl_s[N-1:0];
        any_s = |req;
        off_s = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                off_s = k;
            end else begin
                off_s = off_s;
            end
        end
        sum_s = int'(ptr_r) + off_s;
        if (sum_s >= N) begin
            sum_s = sum_s - N;
        end else begin
            sum_s = sum_s;
        end
        win_s = IW'(sum_s);
    end

    // Next-state and next-output decode; gnt/busy are registered alongside the state
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        sel_s   = sel_r;
        owner_s = owner_r;
        hold_s  = hold_r;
        gnt_s   = {N{1'b0}};
        busy_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    hold_s  = wdata[slice_lo(int'(win_s), WIDTH) +: WIDTH];
                    sel_s   = win_s;
                    gnt_s   = {{(N-1){1'b0}}, 1'b1} << win_s;
                    busy_s  = 1'b1;
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                owner_s = sel_r;
                ptr_s   = (sel_r == LAST_IDX) ? {IW{1'b0}} : (sel_r + ONE_IDX);
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, arbitration pointer, captured data and output registers
    always_ff @(posedge Clock or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= {IW{1'b0}};
            sel_r   <= {IW{1'b0}};
            owner_r <= {IW{1'b0}};
            hold_r  <= {WIDTH{1'b0}};
            gnt_r   <= {N{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            sel_r   <= sel_s;
            owner_r <= owner_s;
            hold_r  <= hold_s;
            gnt_r   <= gnt_s;
            busy_r  <= busy_s;
        end
    end

    assign wr_en_s = (state_r == ST_WRITE);
    assign gnt     = gnt_r;
    assign busy    = busy_r;
    assign owner   = owner_r;

    en_register #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk   (Clock),
        .rst_n (rst),
        .en    (wr_en_s),
        .d     (hold_r),
        .q     (q)
    );

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed, table-driven bench for shared_reg_arbiter (N=4, WIDTH=8).
module tb_shared_reg_arbiter;

    logic        Clock;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        busy;
    logic [1:0]  owner;
    logic [7:0]  q;

    int errors;
    int checks;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic        busy;
        logic [1:0]  owner;
        logic [7:0]  q;
    } vec_t;

    vec_t vecs[18];

    shared_reg_arbiter #(.N(4), .WIDTH(8)) dut (
        .Clock (Clock),
        .rst   (rst),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .busy  (busy),
        .owner (owner),
        .q     (q)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic setv(input int i, input logic [3:0] r, input logic [31:0] wd,
                        input logic [3:0] g, input logic b, input logic [1:0] o, input logic [7:0] qq);
        vecs[i].req   = r;
        vecs[i].wdata = wd;
        vecs[i].gnt   = g;
        vecs[i].busy  = b;
        vecs[i].owner = o;
        vecs[i].q     = qq;
    endtask

    initial begin
        logic [31:0] all_wd;
        errors = 0;
        checks = 0;

        // Each row: drive req/wdata, take one edge, expect outputs after it.
        setv(0,  4'b0100, 32'h443C2211, 4'b0100, 1'b1, 2'd0, 8'h00); // single req 2
        setv(1,  4'b0000, 32'h443C2211, 4'b0000, 1'b0, 2'd2, 8'h3C); // ptr -> 3
        setv(2,  4'b1111, 32'h44332211, 4'b1000, 1'b1, 2'd2, 8'h3C);
        setv(3,  4'b1111, 32'h44332211, 4'b0000, 1'b0, 2'd3, 8'h44);
        setv(4,  4'b1111, 32'h44332211, 4'b0001, 1'b1, 2'd3, 8'h44);
        setv(5,  4'b1111, 32'h44332211, 4'b0000, 1'b0, 2'd0, 8'h11);
        setv(6,  4'b1111, 32'h44332211, 4'b0010, 1'b1, 2'd0, 8'h11);
        setv(7,  4'b1111, 32'h44332211, 4'b0000, 1'b0, 2'd1, 8'h22);
        setv(8,  4'b1111, 32'h44332211, 4'b0100, 1'b1, 2'd1, 8'h22);
        setv(9,  4'b1111, 32'h44332211, 4'b0000, 1'b0, 2'd2, 8'h33);
        setv(10, 4'b1001, 32'h44332211, 4'b1000, 1'b1, 2'd2, 8'h33); // wrap: ptr=3
        setv(11, 4'b1001, 32'h44332211, 4'b0000, 1'b0, 2'd3, 8'h44);
        setv(12, 4'b1001, 32'h44332211, 4'b0001, 1'b1, 2'd3, 8'h44);
        setv(13, 4'b0000, 32'h44332211, 4'b0000, 1'b0, 2'd0, 8'h11); // ptr -> 1
        setv(14, 4'b0110, 32'h44332211, 4'b0010, 1'b1, 2'd0, 8'h11);
        setv(15, 4'b0000, 32'h44332211, 4'b0000, 1'b0, 2'd1, 8'h22);
        setv(16, 4'b0110, 32'h44332211, 4'b0100, 1'b1, 2'd1, 8'h22);
        setv(17, 4'b0000, 32'h44332211, 4'b0000, 1'b0, 2'd2, 8'h33);

        rst   = 1'b0;
        req   = 4'b0000;
        wdata = 32'h0;
        #1;
        check("reset_gnt",   {28'h0, gnt},   32'h0);
        check("reset_busy",  {31'h0, busy},  32'h0);
        check("reset_owner", {30'h0, owner}, 32'h0);
        check("reset_q",     {24'h0, q},     32'h0);
        step();
        step();
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            req   = vecs[i].req;
            wdata = vecs[i].wdata;
            step();
            check($sformatf("vec%0d_gnt", i),   {28'h0, gnt},   {28'h0, vecs[i].gnt});
            check($sformatf("vec%0d_busy", i),  {31'h0, busy},  {31'h0, vecs[i].busy});
            check($sformatf("vec%0d_owner", i), {30'h0, owner}, {30'h0, vecs[i].owner});
            check($sformatf("vec%0d_q", i),     {24'h0, q},     {24'h0, vecs[i].q});
        end

        // Late data change and req withdrawal during WRITE of requester 1 (ptr=3)
        req   = 4'b0010;
        wdata = 32'h44331111;
        step();
        check("late_gnt",  {28'h0, gnt},  32'h2);
        check("late_busy", {31'h0, busy}, 32'h1);
        wdata = 32'h44332211;
        req   = 4'b0000;
        #1;
        check("withdraw_gnt", {28'h0, gnt}, 32'h2);
        step();
        check("late_q",     {24'h0, q},     32'h11);
        check("late_owner", {30'h0, owner}, 32'h1);
        check("late_gnt_off", {28'h0, gnt}, 32'h0);

        // Load A5 via requester 0 (ptr=2), then reset in the middle of the next write
        req   = 4'b0001;
        wdata = 32'h000000A5;
        step();
        req = 4'b0000;
        step();
        check("pre_rst_q",     {24'h0, q},     32'hA5);
        check("pre_rst_owner", {30'h0, owner}, 32'h0);
        req   = 4'b0100;
        wdata = 32'h005A00A5;
        step();
        check("pre_rst_busy", {31'h0, busy}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_q",     {24'h0, q},     32'h0);
        check("arst_gnt",   {28'h0, gnt},   32'h0);
        check("arst_busy",  {31'h0, busy},  32'h0);
        check("arst_owner", {30'h0, owner}, 32'h0);
        req = 4'b0000;
        step();
        step();
        check("arst_hold_q", {24'h0, q}, 32'h0);
        rst   = 1'b1;
        req   = 4'b0010;
        wdata = 32'h00007700;
        step();
        check("post_rst_gnt", {28'h0, gnt}, 32'h2);
        req = 4'b0000;
        step();
        check("post_rst_q",     {24'h0, q},     32'h77);
        check("post_rst_owner", {30'h0, owner}, 32'h1);

        // Fresh reset, then full load from ptr=0: grants 0,1,2,3,0
        rst = 1'b0;
        #1;
        step();
        rst    = 1'b1;
        all_wd = 32'hD4C3B2A1;
        wdata  = all_wd;
        req    = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("all%0d_gnt", i), {28'h0, gnt}, 32'h1 << (i % 4));
            step();
            check($sformatf("all%0d_q", i),     {24'h0, q},     {24'h0, all_wd[(i % 4) * 8 +: 8]});
            check($sformatf("all%0d_owner", i), {30'h0, owner}, 32'(i % 4));
        end
        req = 4'b0000;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
